// File: rtl/gate_pkg.sv
// Shared definitions for the gate scheduler slice.
// Opcode encodings, opcode width and output-register state encoding.
package gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// Combinational W-bit logic-op unit built from per-bit gate cells.
// Opcodes 6 and 7 give a zero result and raise the illegal flag.
module gate_unit
  import gate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    e1,
  input  logic [W-1:0]    e2,
  output logic [W-1:0]    y,
  output logic            illegal
);

  wire [W-1:0] y_not;
  wire [W-1:0] y_and;
  wire [W-1:0] y_or;
  wire [W-1:0] y_xor;
  wire [W-1:0] y_nand;
  wire [W-1:0] y_nor;

  for (genvar i = 0; i < W; i++) begin : g_bit
    not  u_not  (y_not[i],  e1[i]);
    and  u_and  (y_and[i],  e1[i], e2[i]);
    or   u_or   (y_or[i],   e1[i], e2[i]);
    xor  u_xor  (y_xor[i],  e1[i], e2[i]);
    nand u_nand (y_nand[i], e1[i], e2[i]);
    nor  u_nor  (y_nor[i],  e1[i], e2[i]);
  end

  // select the cell row named by the opcode
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_NOT:  y = y_not;
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      OP_NAND: y = y_nand;
      OP_NOR:  y = y_nor;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_sched.sv
// Round-robin scheduler sharing one gate_unit between N requesters.
// Optional s_err output enabled by defining GATE_SCHED_ERR_EN.
module gate_sched
  import gate_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [3*N-1:0]  req_op,
  input  logic [W*N-1:0]  req_e1,
  input  logic [W*N-1:0]  req_e2,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [W-1:0]    s,
  output logic [IW-1:0]   s_id
`ifdef GATE_SCHED_ERR_EN
  ,
  output logic            s_err
`endif
);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g;
  logic [IW-1:0]   ptr_nxt;
  logic            found;
  logic            can_accept;
  logic            grant;
  logic [OP_W-1:0] op_g;
  logic [W-1:0]    e1_g;
  logic [W-1:0]    e2_g;
  logic [W-1:0]    y;
  logic [W-1:0]    res;
  logic            illegal;

  // first valid requester at or after ptr, scanning modulo N
  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req_valid[idx]) begin
        g     = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign can_accept = (state == EMPTY) || s_ready;
  // reset blocks the handshake so nothing is lost in that cycle
  assign grant      = can_accept && found && !rst;
  assign s_valid    = (state == FULL);

  // one-hot ready toward the granted requester only
  always_comb begin
    req_ready    = '0;
    req_ready[g] = grant;
  end

  assign op_g    = req_op[OP_W*g +: OP_W];
  assign e1_g    = req_e1[W*g +: W];
  assign e2_g    = req_e2[W*g +: W];
  assign ptr_nxt = (g == IW'(N - 1)) ? '0 : g + IW'(1);

  gate_unit #(
    .W (W)
  ) u_unit (
    .op      (op_g),
    .e1      (e1_g),
    .e2      (e2_g),
    .y       (y),
    .illegal (illegal)
  );

  assign res = illegal ? '0 : y;

  // output register, state and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      s     <= '0;
      s_id  <= '0;
      ptr   <= '0;
`ifdef GATE_SCHED_ERR_EN
      s_err <= 1'b0;
`endif
    end else if (grant) begin
      state <= FULL;
      s     <= res;
      s_id  <= g;
      ptr   <= ptr_nxt;
`ifdef GATE_SCHED_ERR_EN
      s_err <= illegal;
`endif
    end else if (state == FULL && s_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_gate_sched.sv
// Directed self-checking bench for gate_sched (N=4, W=8).
// Covers s_err checks when GATE_SCHED_ERR_EN is defined.
module tb_gate_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_e1;
  logic [W*N-1:0] req_e2;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s;
  logic [IW-1:0] s_id;
`ifdef GATE_SCHED_ERR_EN
  logic          s_err;
`endif

  int nchk = 0;
  int nerr = 0;

  gate_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_e1    (req_e1),
    .req_e2    (req_e2),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s         (s),
    .s_id      (s_id)
`ifdef GATE_SCHED_ERR_EN
    ,
    .s_err     (s_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[i]      = v;
    req_op[3*i +: 3]  = op;
    req_e1[W*i +: W]  = a;
    req_e2[W*i +: W]  = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_e1    = '0;
    req_e2    = '0;
    s_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    nchk++;
    if (s_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_s_valid got %b want 0", s_valid);
    end
    nchk++;
    if (s !== 8'h00 || s_id !== 2'd0) begin
      nerr++; $display("FAIL reset_s got %h/%0d want 00/0", s, s_id);
    end
    nchk++;
    if (req_ready !== 4'b0000) begin
      nerr++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
`ifdef GATE_SCHED_ERR_EN
    nchk++;
    if (s_err !== 1'b0) begin
      nerr++; $display("FAIL reset_s_err got %b want 0", s_err);
    end
`endif
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_req(0, 1'b1, 3'd1, 8'hF0, 8'h3C);
    s_ready = 1'b1;
    #1;
    nchk++;
    if (req_ready !== 4'b0001) begin
      nerr++; $display("FAIL basic_ready got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (s_valid !== 1'b1 || s !== 8'h30 || s_id !== 2'd0) begin
      nerr++;
      $display("FAIL basic_result got v=%b s=%h id=%0d want v=1 s=30 id=0",
               s_valid, s, s_id);
    end
    @(negedge clk);
    nchk++;
    if (s_valid !== 1'b0) begin
      nerr++; $display("FAIL basic_drain got %b want 0", s_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_id;
    logic [7:0] exp_s;
    do_reset();
    s_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 3'd2, 8'(8'h10 * i), 8'(i));
    for (int k = 0; k < 5; k++) begin
      exp_id = k % N;
      exp_s  = 8'(8'h11 * exp_id);
      #1;
      nchk++;
      if (req_ready !== 4'(1 << exp_id)) begin
        nerr++;
        $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << exp_id));
      end
      @(negedge clk);
      nchk++;
      if (s_valid !== 1'b1 || s_id !== 2'(exp_id) || s !== exp_s) begin
        nerr++;
        $display("FAIL rr_result[%0d] got v=%b id=%0d s=%h want v=1 id=%0d s=%h",
                 k, s_valid, s_id, s, exp_id, exp_s);
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    // pointer is 1 here, only req0 valid -> wraps to 0
    set_req(0, 1'b1, 3'd3, 8'hAA, 8'h0F);
    s_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    s_ready   = 1'b0;
    set_req(2, 1'b1, 3'd1, 8'hFF, 8'h0F);
    set_req(3, 1'b1, 3'd2, 8'h01, 8'h02);
    for (int k = 0; k < 3; k++) begin
      #1;
      nchk++;
      if (req_ready !== 4'b0000) begin
        nerr++; $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready);
      end
      nchk++;
      if (s_valid !== 1'b1 || s !== 8'hA5 || s_id !== 2'd0) begin
        nerr++;
        $display("FAIL stall_hold[%0d] got v=%b s=%h id=%0d want v=1 s=a5 id=0",
                 k, s_valid, s, s_id);
      end
      @(negedge clk);
    end
    s_ready = 1'b1;
    #1;
    nchk++;
    if (req_ready !== 4'b0100) begin
      nerr++; $display("FAIL stall_release got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    nchk++;
    if (s_id !== 2'd2 || s !== 8'h0F) begin
      nerr++; $display("FAIL stall_next got id=%0d s=%h want id=2 s=0f", s_id, s);
    end
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (s_id !== 2'd3 || s !== 8'h03) begin
      nerr++; $display("FAIL stall_next2 got id=%0d s=%h want id=3 s=03", s_id, s);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [2:0] ops [6] = '{3'd0, 3'd4, 3'd5, 3'd3, 3'd1, 3'd2};
    logic [7:0] as  [6] = '{8'hA5, 8'hFF, 8'h00, 8'hAA, 8'hC3, 8'h0F};
    logic [7:0] bs  [6] = '{8'hFF, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h30};
    logic [7:0] exp [6] = '{8'h5A, 8'hF0, 8'hFF, 8'hA5, 8'h03, 8'h3F};
    s_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(1, 1'b1, ops[k], as[k], bs[k]);
      #1;
      nchk++;
      if (req_ready !== 4'b0010) begin
        nerr++; $display("FAIL op_ready[%0d] got %b want 0010", k, req_ready);
      end
      @(negedge clk);
      nchk++;
      if (s_valid !== 1'b1 || s !== exp[k] || s_id !== 2'd1) begin
        nerr++;
        $display("FAIL op[%0d] got v=%b s=%h id=%0d want v=1 s=%h id=1",
                 k, s_valid, s, s_id, exp[k]);
      end
`ifdef GATE_SCHED_ERR_EN
      nchk++;
      if (s_err !== 1'b0) begin
        nerr++; $display("FAIL op_err[%0d] got %b want 0", k, s_err);
      end
`endif
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    s_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(2, 1'b1, 3'(6 + k), 8'hFF, 8'hFF);
      @(negedge clk);
      nchk++;
      if (s_valid !== 1'b1 || s !== 8'h00 || s_id !== 2'd2) begin
        nerr++;
        $display("FAIL illegal[%0d] got v=%b s=%h id=%0d want v=1 s=00 id=2",
                 k, s_valid, s, s_id);
      end
`ifdef GATE_SCHED_ERR_EN
      nchk++;
      if (s_err !== 1'b1) begin
        nerr++; $display("FAIL illegal_err[%0d] got %b want 1", k, s_err);
      end
`endif
    end
    set_req(2, 1'b1, 3'd2, 8'h00, 8'h81);
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (s !== 8'h81) begin
      nerr++; $display("FAIL illegal_recover got %h want 81", s);
    end
`ifdef GATE_SCHED_ERR_EN
    nchk++;
    if (s_err !== 1'b0) begin
      nerr++; $display("FAIL illegal_clear got %b want 0", s_err);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    s_ready = 1'b0;
    set_req(3, 1'b1, 3'd1, 8'hFF, 8'hFF);
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (s_valid !== 1'b1 || s !== 8'hFF || s_id !== 2'd3) begin
      nerr++;
      $display("FAIL mid_full got v=%b s=%h id=%0d want v=1 s=ff id=3",
               s_valid, s, s_id);
    end
    set_req(1, 1'b1, 3'd2, 8'h12, 8'h00);
    set_req(2, 1'b1, 3'd2, 8'h34, 8'h00);
    rst     = 1'b1;
    s_ready = 1'b1;
    #1;
    nchk++;
    if (req_ready !== 4'b0000) begin
      nerr++; $display("FAIL mid_rst_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (s_valid !== 1'b0 || s !== 8'h00 || s_id !== 2'd0) begin
      nerr++;
      $display("FAIL mid_rst_out got v=%b s=%h id=%0d want v=0 s=00 id=0",
               s_valid, s, s_id);
    end
    #1;
    nchk++;
    if (req_ready !== 4'b0010) begin
      nerr++; $display("FAIL mid_first_grant got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    nchk++;
    if (s_valid !== 1'b1 || s_id !== 2'd1 || s !== 8'h12) begin
      nerr++;
      $display("FAIL mid_result got v=%b id=%0d s=%h want v=1 id=1 s=12",
               s_valid, s_id, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_ops();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
